// File: rtl/copro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : copro_pkg
// Description : Shared definitions for the GCD/LCM custom-instruction
//               coprocessor: FSM state type, opcodes, writeback select.
// Revision    : 1.0 - initial release
// ============================================================================
package copro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EVEN  = 3'd1,
        ST_STEIN = 3'd2,
        ST_DIV   = 3'd3,
        ST_MUL   = 3'd4,
        ST_DONE  = 3'd5
    } copro_state_t;

    localparam logic [6:0] OP_GCD          = 7'b0000000;
    localparam logic [6:0] OP_LCM          = 7'b0000001;
    localparam logic [1:0] RESULTSRC_COPRO = 2'b11;

endpackage
`default_nettype wire

// File: rtl/gcd_lcm_copro_if.sv
`default_nettype none
// ============================================================================
// Module      : gcd_lcm_copro_if
// Description : Custom-instruction handshake between core (master) and the
//               GCD/LCM coprocessor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface gcd_lcm_copro_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (
        output start, op, srca, srcb,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, op, srca, srcb,
        output busy, done, result, ovf
    );
endinterface
`default_nettype wire

// File: rtl/copro_divmul.sv
`default_nettype none
// ============================================================================
// Module      : copro_divmul
// Description : Sequential restoring divider and shift-add multiplier sharing
//               one step counter. Each operation runs WIDTH cycles while its
//               go level is held; fin marks the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module copro_divmul #(
    parameter int WIDTH = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               go_div,
    input  wire logic               go_mul,
    input  wire logic [WIDTH-1:0]   dividend,
    input  wire logic [WIDTH-1:0]   divisor,
    input  wire logic [WIDTH-1:0]   mplier,
    input  wire logic [WIDTH-1:0]   mcand,
    output logic      [WIDTH-1:0]   q,
    output logic      [2*WIDTH-1:0] p,
    output logic                    fin
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [2*WIDTH-1:0] r_p;

    logic [IW-1:0]      w_idx;
    logic               w_first;
    logic [WIDTH-1:0]   w_rem_base;
    logic [WIDTH-1:0]   w_q_base;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_p_base;
    logic [2*WIDTH-1:0] w_addend;

    // One division step and one multiply step; step 0 starts from cleared
    // partials so no separate load cycle is needed.
    always_comb begin
        w_idx      = r_cnt[IW-1:0];
        w_first    = (r_cnt == '0);
        w_rem_base = w_first ? '0 : r_rem;
        w_q_base   = w_first ? '0 : r_q;
        w_trial    = {w_rem_base, dividend[IW'(WIDTH-1) - w_idx]};
        // Trial is below 2*divisor, so a borrow shows up in the top bit.
        w_diff     = w_trial - {1'b0, divisor};
        w_ge       = ~w_diff[WIDTH];
        w_p_base   = w_first ? '0 : r_p;
        w_addend   = mplier[w_idx] ? ({{WIDTH{1'b0}}, mcand} << w_idx) : '0;
        p          = w_p_base + w_addend;
        q          = r_q;
        fin        = (go_div | go_mul) && (r_cnt == CW'(WIDTH-1));
    end

    // Step counter and partial-result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_p   <= '0;
        end else begin
            if (go_div | go_mul) begin
                r_cnt <= fin ? '0 : r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (go_div) begin
                r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_q   <= {w_q_base[WIDTH-2:0], w_ge};
            end
            if (go_mul) begin
                r_p <= p;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_lcm_copro.sv
`default_nettype none
// ============================================================================
// Module      : gcd_lcm_copro
// Description : Multi-cycle GCD/LCM coprocessor. Binary (Stein) GCD, then for
//               LCM an exact division A/g followed by a multiply by B.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_lcm_copro
    import copro_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    gcd_lcm_copro_if.slave    bus
);
    localparam int   KW      = $clog2(WIDTH);
    localparam logic OPR_LCM = OP_LCM[0];

    copro_state_t     r_state;
    copro_state_t     w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_opr;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic             w_zero;
    logic [WIDTH-1:0] w_g;
    logic             w_go_div;
    logic             w_go_mul;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_q;
    logic [2*WIDTH-1:0] w_p;
    logic             w_fin;

    copro_divmul #(.WIDTH(WIDTH)) u_divmul (
        .clk      (clk),
        .reset    (reset),
        .go_div   (w_go_div),
        .go_mul   (w_go_mul),
        .dividend (r_a),
        .divisor  (r_g),
        .mplier   (w_q),
        .mcand    (r_b),
        .q        (w_q),
        .p        (w_p),
        .fin      (w_fin)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE always falls back to IDLE so a held start
    // cannot retrigger from DONE.
    always_comb begin
        w_zero       = (bus.srca == '0) || (bus.srcb == '0);
        w_g          = r_y << r_k;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next_state = w_zero ? ST_DONE : ST_EVEN;
            ST_EVEN:  if (r_x[0] | r_y[0]) w_next_state = ST_STEIN;
            ST_STEIN: if (r_x == '0) w_next_state = (r_opr == OPR_LCM) ? ST_DIV : ST_DONE;
            ST_DIV:   if (w_fin) w_next_state = ST_MUL;
            ST_MUL:   if (w_fin) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        w_busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
        w_done   = (r_state == ST_DONE);
        w_go_div = (r_state == ST_DIV);
        w_go_mul = (r_state == ST_MUL);
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;

    // Stein datapath; result/ovf only change on the edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_opr    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_k      <= '0;
            r_g      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.srca;
                        r_b   <= bus.srcb;
                        r_opr <= bus.op;
                        r_x   <= bus.srca;
                        r_y   <= bus.srcb;
                        r_k   <= '0;
                        if (w_zero) begin
                            r_result <= (bus.op == OPR_LCM) ? '0 : (bus.srca | bus.srcb);
                            r_ovf    <= 1'b0;
                        end
                    end
                end
                ST_EVEN: begin
                    if (!(r_x[0] | r_y[0])) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_STEIN: begin
                    if (r_x == '0) begin
                        r_g <= w_g;
                        if (r_opr != OPR_LCM) begin
                            r_result <= w_g;
                            r_ovf    <= 1'b0;
                        end
                    end else if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x >= r_y) begin
                        r_x <= r_x - r_y;
                    end else begin
                        r_y <= r_y - r_x;
                    end
                end
                ST_MUL: begin
                    if (w_fin) begin
                        r_result <= w_p[WIDTH-1:0];
                        r_ovf    <= |w_p[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
